// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and per-step helper functions
// used by the chained accelerator and its single-step datapath.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_ACCUM,
    ST_OUTPUT
  } state_t;

  localparam logic [31:0] IV [4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Shift amount repeats every four steps within each quarter.
  function automatic logic [4:0] s_amt(input logic [5:0] i);
    case ({i[5:4], i[1:0]})
      4'h0: s_amt = 5'd7;
      4'h1: s_amt = 5'd12;
      4'h2: s_amt = 5'd17;
      4'h3: s_amt = 5'd22;
      4'h4: s_amt = 5'd5;
      4'h5: s_amt = 5'd9;
      4'h6: s_amt = 5'd14;
      4'h7: s_amt = 5'd20;
      4'h8: s_amt = 5'd4;
      4'h9: s_amt = 5'd11;
      4'ha: s_amt = 5'd16;
      4'hb: s_amt = 5'd23;
      4'hc: s_amt = 5'd6;
      4'hd: s_amt = 5'd10;
      4'he: s_amt = 5'd15;
      default: s_amt = 5'd21;
    endcase
  endfunction

  function automatic logic [3:0] g_idx(input logic [5:0] i);
    logic [3:0] n;
    n = i[3:0];
    case (i[5:4])
      2'd0: g_idx = n;
      2'd1: g_idx = 4'(n * 4'd5 + 4'd1);
      2'd2: g_idx = 4'(n * 4'd3 + 4'd5);
      default: g_idx = 4'(n * 4'd7);
    endcase
  endfunction

  function automatic logic [31:0] f_fn(input logic [1:0] q, input logic [31:0] b, input logic [31:0] c,
                                       input logic [31:0] d);
    case (q)
      2'd0: f_fn = (b & c) | (~b & d);
      2'd1: f_fn = (d & b) | (~d & c);
      2'd2: f_fn = b ^ c ^ d;
      default: f_fn = c ^ (b | ~d);
    endcase
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: mixes message word i_m into (A,B,C,D) for step i_step.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_m,
  input  logic [5:0]  i_step,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d
);

  logic [31:0] w_sum;
  logic [31:0] w_rot;
  logic [4:0]  w_s;

  assign w_sum = i_a + f_fn(i_step[5:4], i_b, i_c, i_d) + K_TAB[i_step] + i_m;
  assign w_s   = s_amt(i_step);
  assign w_rot = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));

  assign o_a = i_d;
  assign o_b = i_b + w_rot;
  assign o_c = i_b;
  assign o_d = i_c;

endmodule

// File: rtl/md5_chained_accelerator.sv
// Multi-block MD5 engine: fetches pre-padded blocks from word memory, chains the
// compression across blocks and streams the digest out one word per cycle.
module md5_chained_accelerator
  import md5_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int NBLK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [NBLK_WIDTH-1:0] num_blocks,
  input  logic [31:0]           messageChunk,
  output logic [ADDR_WIDTH-1:0] messageAddress,
  output logic                  mem_read,
  output logic                  busy,
  output logic [31:0]           hashValue,
  output logic [1:0]            digest_index,
  output logic                  output_valid
);

  state_t                r_state, w_state_next;
  logic [6:0]            r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_blk_addr, w_blk_addr_next, r_addr, w_addr_next;
  logic [NBLK_WIDTH-1:0] r_nblk, r_blk_cnt, w_blk_cnt_inc;
  logic [31:0]           r_msg [16];
  logic [31:0]           r_chain [4];
  logic [31:0]           w_chain_next [4];
  logic [31:0]           r_work [4];
  logic [31:0]           w_step [4];
  logic [31:0]           r_hash, w_hash_next;
  logic [1:0]            r_didx, w_didx_next;
  logic                  r_mem_read, w_mem_read_next, r_busy, w_busy_next, r_ovalid, w_ovalid_next;
  logic [3:0]            w_wr_idx;

  assign w_blk_cnt_inc = r_blk_cnt + NBLK_WIDTH'(1);
  assign w_wr_idx      = 4'(r_cnt - 7'd1);

  md5_step u_step (
    .i_a   (r_work[0]),
    .i_b   (r_work[1]),
    .i_c   (r_work[2]),
    .i_d   (r_work[3]),
    .i_m   (r_msg[g_idx(r_cnt[5:0])]),
    .i_step(r_cnt[5:0]),
    .o_a   (w_step[0]),
    .o_b   (w_step[1]),
    .o_c   (w_step[2]),
    .o_d   (w_step[3])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 7'd1;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (start) w_state_next = (num_blocks == '0) ? ST_OUTPUT : ST_LOAD;
      end
      ST_LOAD: if (r_cnt == 7'd16) begin
        w_state_next = ST_ROUND;
        w_cnt_next   = '0;
      end
      ST_ROUND: if (r_cnt == 7'd63) begin
        w_state_next = ST_ACCUM;
        w_cnt_next   = '0;
      end
      ST_ACCUM: begin
        w_state_next = (w_blk_cnt_inc < r_nblk) ? ST_LOAD : ST_OUTPUT;
        w_cnt_next   = '0;
      end
      ST_OUTPUT: if (r_cnt == 7'd3) begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Chaining words return to IV as the last digest word leaves.
  always_comb begin
    w_blk_addr_next = r_blk_addr;
    if (r_state == ST_IDLE && start) w_blk_addr_next = base_addr;
    else if (r_state == ST_ACCUM) w_blk_addr_next = r_blk_addr + ADDR_WIDTH'(16);
    for (int n = 0; n < 4; n++) begin
      w_chain_next[n] = r_chain[n];
      if (r_state == ST_ACCUM) w_chain_next[n] = r_chain[n] + r_work[n];
      else if (r_state == ST_OUTPUT && r_cnt == 7'd3) w_chain_next[n] = IV[n];
    end
  end

  // Outputs are computed from the upcoming state so they can be registered.
  always_comb begin
    w_mem_read_next = (w_state_next == ST_LOAD) && (w_cnt_next < 7'd16);
    w_addr_next     = r_addr;
    if (w_mem_read_next) w_addr_next = w_blk_addr_next + ADDR_WIDTH'(w_cnt_next[3:0]);
    w_ovalid_next = (w_state_next == ST_OUTPUT);
    w_didx_next   = '0;
    w_hash_next   = '0;
    if (w_ovalid_next) begin
      w_didx_next = w_cnt_next[1:0];
      w_hash_next = w_chain_next[w_cnt_next[1:0]];
    end
    w_busy_next = (w_state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blk_addr <= '0;
      r_nblk     <= '0;
      r_blk_cnt  <= '0;
      r_chain    <= IV;
      r_addr     <= '0;
      r_mem_read <= 1'b0;
      r_busy     <= 1'b0;
      r_ovalid   <= 1'b0;
      r_didx     <= '0;
      r_hash     <= '0;
    end else begin
      r_blk_addr <= w_blk_addr_next;
      if (r_state == ST_IDLE && start) begin
        r_nblk    <= num_blocks;
        r_blk_cnt <= '0;
      end else if (r_state == ST_ACCUM) begin
        r_blk_cnt <= w_blk_cnt_inc;
      end
      r_chain    <= w_chain_next;
      r_addr     <= w_addr_next;
      r_mem_read <= w_mem_read_next;
      r_busy     <= w_busy_next;
      r_ovalid   <= w_ovalid_next;
      r_didx     <= w_didx_next;
      r_hash     <= w_hash_next;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD && r_cnt != 7'd0) r_msg[w_wr_idx] <= messageChunk;
    if (r_state == ST_LOAD && r_cnt == 7'd16) r_work <= r_chain;
    else if (r_state == ST_ROUND) r_work <= w_step;
  end

  assign messageAddress = r_addr;
  assign mem_read       = r_mem_read;
  assign busy           = r_busy;
  assign hashValue      = r_hash;
  assign digest_index   = r_didx;
  assign output_valid   = r_ovalid;

endmodule

// File: tb/tb_md5_chained_accelerator.sv
// Bench for md5_chained_accelerator: a synchronous message memory, a software
// MD5 reference (byte padding + compression) and cycle-exact job checks.
module tb_md5_chained_accelerator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [3:0]  num_blocks = '0;
  logic [31:0] messageChunk = '0;
  logic [7:0]  messageAddress;
  logic        mem_read;
  logic        busy;
  logic [31:0] hashValue;
  logic [1:0]  digest_index;
  logic        output_valid;

  md5_chained_accelerator #(.ADDR_WIDTH(8), .NBLK_WIDTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_blocks    (num_blocks),
    .messageChunk  (messageChunk),
    .messageAddress(messageAddress),
    .mem_read      (mem_read),
    .busy          (busy),
    .hashValue     (hashValue),
    .digest_index  (digest_index),
    .output_valid  (output_valid)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_read) messageChunk <= mem[messageAddress];

  int          total = 0;
  int          bad = 0;
  logic [7:0]  msg_b [$];
  logic [31:0] msg_w [$];
  logic [31:0] exp_dig [4];
  logic [31:0] k_tab [64];
  int          s_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void pad_msg();
    logic [63:0] bits;
    logic [7:0]  p [$];
    bits = 64'(msg_b.size()) * 64'd8;
    p = msg_b;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int j = 0; j < 8; j++) p.push_back(bits[8*j +: 8]);
    msg_w.delete();
    for (int j = 0; j < p.size() / 4; j++)
      msg_w.push_back({p[4*j+3], p[4*j+2], p[4*j+1], p[4*j]});
  endfunction

  function automatic void md5_ref(input int nblk);
    logic [31:0] h [4];
    logic [31:0] a, b, c, d, f, t;
    int g, s;
    h = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};
    for (int blk = 0; blk < nblk; blk++) begin
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      for (int i = 0; i < 64; i++) begin
        if (i < 16) begin f = (b & c) | (~b & d); g = i; end
        else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        else if (i < 48) begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        else begin f = c ^ (b | ~d); g = (7 * i) % 16; end
        s = s_tab[(i / 16) * 4 + i % 4];
        t = a + f + k_tab[i] + msg_w[16 * blk + g];
        t = (t << s) | (t >> (32 - s));
        a = d; d = c; c = b; b = b + t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d;
    end
    exp_dig = h;
  endfunction

  function automatic void load_mem(input logic [7:0] base);
    for (int j = 0; j < msg_w.size(); j++) mem[8'(int'(base) + j)] = msg_w[j];
  endfunction

  // Runs one job and checks read schedule, digest timing/values and busy.
  task automatic run_job(input string tag, input logic [7:0] base, input int n, input bit use_ref,
                         input int pulse_at);
    int nreads = 0;
    int stray = 0;
    int last = 82 * n + 5;
    if (use_ref) md5_ref(n);
    @(negedge clk);
    start = 1'b1; base_addr = base; num_blocks = 4'(n);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; base_addr = 8'($urandom); num_blocks = 4'($urandom);
      end
      if (mem_read) begin
        int j = nreads;
        check_val({tag, "_rd"}, {32'(c), messageAddress},
                  {32'(1 + 82 * (j / 16) + j % 16), 8'(int'(base) + 16 * (j / 16) + j % 16)});
        nreads++;
      end
      if (c >= 82 * n + 1 && c <= 82 * n + 4) begin
        int k = c - (82 * n + 1);
        check_val({tag, "_ov"}, 64'(output_valid), 64'd1);
        check_val({tag, "_idx"}, 64'(digest_index), 64'(k));
        check_val({tag, "_hash"}, 64'(hashValue), 64'(exp_dig[k]));
      end else if (output_valid) begin
        stray++;
      end
      if (c == 1 || c == last - 1) check_val({tag, "_busy"}, 64'(busy), 64'd1);
      if (c == last) check_val({tag, "_idle"}, 64'(busy), 64'd0);
      if (pulse_at > 0 && c == pulse_at) begin
        start = 1'b1; base_addr = 8'($urandom); num_blocks = 4'($urandom);
      end else if (pulse_at > 0 && c == pulse_at + 1) begin
        start = 1'b0;
      end
    end
    check_val({tag, "_nreads"}, 64'(nreads), 64'(16 * n));
    check_val({tag, "_stray_ov"}, 64'(stray), 64'd0);
    $display("job %s base=%02h n=%0d digest=%08h %08h %08h %08h", tag, base, n,
             exp_dig[0], exp_dig[1], exp_dig[2], exp_dig[3]);
  endtask

  initial begin
    logic [7:0] rb;
    int         len;

    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k_tab[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    check_val("rst_mem_read", 64'(mem_read), 64'd0);
    check_val("rst_ov", 64'(output_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_addr", 64'(messageAddress), 64'd0);
    check_val("rst_hash", 64'(hashValue), 64'd0);
    check_val("rst_idx", 64'(digest_index), 64'd0);
    reset = 1'b0;

    msg_b = '{8'h61, 8'h62, 8'h63};
    pad_msg(); load_mem(8'h00);
    exp_dig = '{32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};
    run_job("abc", 8'h00, 1, 1'b0, 0);

    msg_b.delete();
    pad_msg(); load_mem(8'h30);
    exp_dig = '{32'hd98c1dd4, 32'h04b2008f, 32'h980980e9, 32'h7e42f8ec};
    run_job("empty", 8'h30, 1, 1'b0, 0);

    msg_b.delete();
    for (int j = 0; j < 56; j++) msg_b.push_back(8'h61);
    pad_msg(); load_mem(8'h40);
    run_job("a56", 8'h40, 2, 1'b1, 0);

    run_job("nblk0", 8'h10, 0, 1'b1, 0);

    msg_b.delete();
    len = $urandom_range(0, 55);
    for (int j = 0; j < len; j++) begin rb = 8'($urandom); msg_b.push_back(rb); end
    pad_msg(); load_mem(8'hF8);
    run_job("wrap", 8'hF8, 1, 1'b1, 0);

    for (int t = 0; t < 4; t++) begin
      logic [7:0] b;
      msg_b.delete();
      len = $urandom_range(0, 180);
      for (int j = 0; j < len; j++) begin rb = 8'($urandom); msg_b.push_back(rb); end
      pad_msg();
      b = 8'($urandom);
      load_mem(b);
      run_job($sformatf("rand%0d", t), b, msg_w.size() / 16, 1'b1, (t == 1) ? 30 : 0);
    end

    // Start pulsed mid-ROUND must not disturb the running job.
    msg_b = '{8'h61, 8'h62, 8'h63};
    pad_msg(); load_mem(8'h00);
    exp_dig = '{32'h98500190, 32'hb04fd23c, 32'h7d3f96d6, 32'h727fe128};
    run_job("abc_pulse", 8'h00, 1, 1'b0, 45);

    @(negedge clk);
    start = 1'b1; base_addr = 8'h00; num_blocks = 4'd1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_mem_read", 64'(mem_read), 64'd0);
    check_val("abort_ov", 64'(output_valid), 64'd0);
    reset = 1'b0;
    $display("job abort at cycle 40 busy=%0b", busy);
    run_job("abc_restart", 8'h00, 1, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md5_chained_accelerator.md
# md5_chained_accelerator

Multi-block MD5 engine that replaces the single-block accelerator. On `start` it fetches `num_blocks` pre-padded 512-bit blocks from a word-wide synchronous message memory, starting at `base_addr`. It chains the MD5 compression across blocks and streams the 128-bit digest out as four 32-bit words. It sits between the message `memory` instance and the host/bench, using the same read-enable/address memory handshake.

## Interface
- `ADDR_WIDTH`, 8: message memory word-address width; addresses wrap modulo 2^ADDR_WIDTH.
- `NBLK_WIDTH`, 4: width of `num_blocks`; up to 2^NBLK_WIDTH−1 blocks per job.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high; dominates all other inputs.
- `start` in 1: job request, sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: word address of block 0, word 0; sampled with `start`.
- `num_blocks` in NBLK_WIDTH: block count; sampled with `start`.
- `messageChunk` in 32: memory read data, valid the cycle after `mem_read`.
- `messageAddress` out ADDR_WIDTH: memory word address.
- `mem_read` out 1: memory read enable.
- `busy` out 1: high in every state except IDLE.
- `hashValue` out 32: digest word; meaningful only while `output_valid`.
- `digest_index` out 2: digest word index 0..3 (A, B, C, D).
- `output_valid` out 1: qualifies `hashValue` and `digest_index`.

## Operation
- Memory layout: word k of block b is at `base_addr + 16*b + k`, truncated to ADDR_WIDTH. Words are already in MD5 little-endian M[k] form. Padding is the producer's job.
- States: IDLE, LOAD, ROUND, ACCUM, OUTPUT.
- IDLE: the chaining registers hold IV 0x67452301, 0xefcdab89, 0x98badcfe, 0x10325476.
  - `start`=1 latches `base_addr` and `num_blocks`.
  - Next state is LOAD, or OUTPUT if `num_blocks`==0.
- LOAD: 17 cycles.
  - Cycles 0..15: `mem_read`=1 and `messageAddress` = block base + cycle.
  - Cycles 1..16: `messageChunk` is written into the 16-word buffer M[0..15].
- ROUND: 64 cycles, one MD5 step per cycle, step i = 0..63.
  - f = F/G/H/I per quarter.
  - g = i, (5i+1)%16, (3i+5)%16, 7i%16 per quarter.
  - B' = B + rotl(A + f + K[i] + M[g], S[i]), then (A,B,C,D) ← (D,B',B,C).
  - All additions are mod 2^32.
- ACCUM: 1 cycle.
  - Each chaining word += its working register, mod 2^32.
  - Block counter increments.
  - Next state is LOAD if blocks remain, else OUTPUT.
- OUTPUT: 4 cycles with `output_valid`=1, `digest_index` = 0,1,2,3 and `hashValue` = A,B,C,D. Then IDLE, with the chaining registers re-initialised to IV.
- `start` while busy: ignored, with no effect on the current job.
- Reset values: `mem_read`=0, `output_valid`=0, `busy`=0, `messageAddress`=0, `hashValue`=0, `digest_index`=0. FSM goes to IDLE and the chaining registers to IV.
- Reset mid-job: abort at the next edge with no partial digest output. A new `start` is accepted the cycle after `reset` deasserts.

## Timing
- `start` sampled at edge T. Block b occupies cycles T+1+82b … T+82+82b:
  - LOAD: 17 cycles.
  - ROUND: 64 cycles.
  - ACCUM: 1 cycle.
- First `mem_read` is at cycle T+1. Read data arrives at T+2.
- OUTPUT spans cycles T+1+82N … T+4+82N. `busy` falls at T+5+82N.
- With `num_blocks`==0, OUTPUT spans T+1 … T+4 and no memory reads occur.
- `start` is accepted again in the first IDLE cycle, T+5+82N.
- All outputs are registered.

## Structure
- Package `md5_pkg`:
  - K[0..63] constants.
  - S[0..63] shift amounts.
  - IV words.
  - State encoding.
  - Functions for F/G/H/I and g-index.
- Sub-module `md5_step`: combinational single step taking (A,B,C,D, M[g], i) and producing the next (A,B,C,D).
- The top level holds the FSM, counters, message buffer, chaining registers and output sequencing.

## Test plan
- "abc" single padded block, base 0, N=1 → output at T+83..T+86: 0x98500190, 0xb04fd23c, 0x7d3f96d6, 0x727fe128.
- Empty-message padded block at base 0x30, N=1 → reads 0x30..0x3F; output 0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec.
- 56×'a' message (2 padded blocks), N=2 → digest matches the software MD5 model; output at T+165..T+168.
- N=0 → no `mem_read`; output is the IV words at T+1..T+4.
- `base_addr`=0xF8, ADDR_WIDTH=8, N=1 → addresses 0xF8..0xFF, 0x00..0x07.
- `start` pulsed during ROUND is ignored. `reset` at T+40 drops `busy` and `mem_read` at the next edge with no `output_valid`. A restarted "abc" job then yields the correct digest.
